// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: default widths and control encodings.
package id_ex_stage_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned REG_AW_DEF    = 5;
    localparam int unsigned ALUCTRL_W_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned RESSRC_W      = 2;
    localparam int unsigned FUNCT3_W      = 3;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_ctrl_e;

endpackage

// File: rtl/id_ex_stage_pipe_reg.sv
// Generic pipeline flop: async active-low reset, synchronous clear (wins), then enable.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-Execute pipeline register with stall/flush handling and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned ALUCTRL_W = ALUCTRL_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 ALUSrcD,
    input  logic [2:0]           Funct3D,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [REG_AW-1:0]    Rs1D,
    input  logic [REG_AW-1:0]    Rs2D,
    input  logic [REG_AW-1:0]    RdD,
    output logic                 ValidE,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic [2:0]           Funct3E,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [REG_AW-1:0]    Rs1E,
    output logic [REG_AW-1:0]    Rs2E,
    output logic [REG_AW-1:0]    RdE,
    output logic [CNT_W-1:0]     BubbleCntE
);

    localparam int unsigned CTRL_W = 5 + RESSRC_W + ALUCTRL_W + 1 + FUNCT3_W + REG_AW;
    localparam int unsigned DATA_W = 5 * XLEN + 2 * REG_AW;

    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              load_en;

    assign load_en = ~StallE;

    // An invalid decode slot still moves its operands but must have no architectural effect.
    assign ctrl_d = ValidD ? {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                              ALUControlD, ALUSrcD, Funct3D, RdD}
                           : '0;
    assign data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D};

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (load_en),
        .clr_i  (FlushE),
        .d_i    (ctrl_d),
        .q_o    (ctrl_q)
    );

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (load_en),
        .clr_i  (FlushE),
        .d_i    (data_d),
        .q_o    (data_q)
    );

    assign {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
            ALUControlE, ALUSrcE, Funct3E, RdE} = ctrl_q;
    assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E} = data_q;

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // Saturating bubble count; only flushes advance it.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCntE = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor pops and compares.
module tb_id_ex_stage;

    logic        clock;
    logic        reset_n;
    logic        StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  Funct3D;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCntE;

    logic        s_ValidE, s_RegWriteE, s_MemWriteE, s_JumpE, s_BranchE, s_ALUSrcE;
    logic [1:0]  s_ResultSrcE;
    logic [3:0]  s_ALUControlE;
    logic [2:0]  s_Funct3E;
    logic [31:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]  s_BubbleCntE;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  ressrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [3:0]  aluctrl;
        logic        alusrc;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] imm;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t model;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage dut (
        .clock(clock), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCntE(BubbleCntE)
    );

    id_ex_stage #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(s_ValidE), .RegWriteE(s_RegWriteE), .ResultSrcE(s_ResultSrcE),
        .MemWriteE(s_MemWriteE), .JumpE(s_JumpE), .BranchE(s_BranchE),
        .ALUControlE(s_ALUControlE), .ALUSrcE(s_ALUSrcE), .Funct3E(s_Funct3E),
        .RD1E(s_RD1E), .RD2E(s_RD2E), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E),
        .ImmExtE(s_ImmExtE), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE),
        .BubbleCntE(s_BubbleCntE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of one clock edge, straight from the stage's rules.
    task automatic model_edge();
        exp_t n;
        n = model;
        if (!reset_n) begin
            n = '0;
        end else if (FlushE) begin
            n = '0;
            n.cnt  = (int'(model.cnt) < 65535) ? model.cnt + 16'd1 : model.cnt;
            n.cnt4 = (int'(model.cnt4) < 15) ? model.cnt4 + 4'd1 : model.cnt4;
        end else if (!StallE) begin
            n.valid    = ValidD;
            n.regwrite = ValidD ? RegWriteD : 1'b0;
            n.ressrc   = ValidD ? ResultSrcD : 2'd0;
            n.memwrite = ValidD ? MemWriteD : 1'b0;
            n.jump     = ValidD ? JumpD : 1'b0;
            n.branch   = ValidD ? BranchD : 1'b0;
            n.aluctrl  = ValidD ? ALUControlD : 4'd0;
            n.alusrc   = ValidD ? ALUSrcD : 1'b0;
            n.funct3   = ValidD ? Funct3D : 3'd0;
            n.rd       = ValidD ? RdD : 5'd0;
            n.rs1 = Rs1D; n.rs2 = Rs2D;
            n.rd1 = RD1D; n.rd2 = RD2D; n.pc = PCD; n.pcp4 = PCPlus4D; n.imm = ImmExtD;
        end
        model = n;
    endtask

    // Inputs are set just after a falling edge; predict, enqueue, advance one cycle.
    task automatic tick();
        model_edge();
        exp_q.push_back(model);
        @(negedge clock);
    endtask

    task automatic rand_inputs();
        ValidD = 1'($urandom); RegWriteD = 1'($urandom); ResultSrcD = 2'($urandom);
        MemWriteD = 1'($urandom); JumpD = 1'($urandom); BranchD = 1'($urandom);
        ALUControlD = 4'($urandom); ALUSrcD = 1'($urandom); Funct3D = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
        ImmExtD = $urandom; Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                      ALUSrcE, Funct3E, RdE, Rs1E, Rs2E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                      BubbleCntE, s_BubbleCntE};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
                end
            end
        end
    end

    initial begin : driver
        model = '0;
        reset_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        rand_inputs();
        tick(); tick();
        reset_n = 1'b1;
        chk("reset_bubble", 64'(BubbleCntE), 64'd0);

        // Directed load
        rand_inputs();
        ImmExtD = 32'h0000_07E5; RD1D = 32'h1234_5678; RdD = 5'd9; RegWriteD = 1'b1;
        ValidD = 1'b1;
        tick();
        chk("load_imm", 64'(ImmExtE), 64'h7E5);
        chk("load_rd1", 64'(RD1E), 64'h1234_5678);
        chk("load_rd", 64'(RdE), 64'd9);
        chk("load_regwrite", 64'(RegWriteE), 64'd1);
        chk("load_valid", 64'(ValidE), 64'd1);

        // Stall holds for three edges while D changes
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
        end
        chk("stall_imm", 64'(ImmExtE), 64'h7E5);
        chk("stall_rd1", 64'(RD1E), 64'h1234_5678);
        StallE = 1'b0; ImmExtD = 32'h0000_0ABC; ValidD = 1'b1;
        tick();
        chk("release_imm", 64'(ImmExtE), 64'hABC);

        // Flush beats stall
        rand_inputs(); ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; RdD = 5'd7;
        FlushE = 1'b1; StallE = 1'b1;
        tick();
        chk("flush_valid", 64'(ValidE), 64'd0);
        chk("flush_regwrite", 64'(RegWriteE), 64'd0);
        chk("flush_memwrite", 64'(MemWriteE), 64'd0);
        chk("flush_rd", 64'(RdE), 64'd0);
        chk("flush_bubble", 64'(BubbleCntE), 64'd1);
        StallE = 1'b0;

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            tick();
        end
        chk("sat_cnt4", 64'(s_BubbleCntE), 64'd15);
        chk("sat_cnt16", 64'(BubbleCntE), 64'd21);
        FlushE = 1'b0;

        // Invalid decode slot
        rand_inputs(); ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; RD1D = 32'hCAFE_F00D;
        tick();
        chk("inv_valid", 64'(ValidE), 64'd0);
        chk("inv_regwrite", 64'(RegWriteE), 64'd0);
        chk("inv_memwrite", 64'(MemWriteE), 64'd0);
        chk("inv_rd1", 64'(RD1E), 64'hCAFE_F00D);
        chk("inv_bubble", 64'(BubbleCntE), 64'd21);

        // Asynchronous reset between edges with all inputs nonzero
        rand_inputs(); ValidD = 1'b1; RD1D = RD1D | 32'h1;
        tick();
        rand_inputs();
        ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1;
        ALUSrcD = 1'b1; ResultSrcD = ResultSrcD | 2'd1; ALUControlD = ALUControlD | 4'd1;
        Funct3D = Funct3D | 3'd1; RD1D = RD1D | 32'd1; RD2D = RD2D | 32'd1; PCD = PCD | 32'd1;
        PCPlus4D = PCPlus4D | 32'd1; ImmExtD = ImmExtD | 32'd1; Rs1D = Rs1D | 5'd1;
        Rs2D = Rs2D | 5'd1; RdD = RdD | 5'd1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_ctrl", 64'({ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                                ALUControlE, ALUSrcE, Funct3E, RdE, Rs1E, Rs2E}), 64'd0);
        chk("async_rd", 64'({RD1E, RD2E}), 64'd0);
        chk("async_pc", 64'({PCE, PCPlus4E}), 64'd0);
        chk("async_imm", 64'(ImmExtE), 64'd0);
        chk("async_bubble", 64'({BubbleCntE, s_BubbleCntE}), 64'd0);
        tick();
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            ValidD = ($urandom_range(3, 0) != 0);
            FlushE = ($urandom_range(7, 0) == 0);
            StallE = ($urandom_range(3, 0) == 0);
            tick();
        end
        FlushE = 1'b0; StallE = 1'b0;
        @(negedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
